// File: rtl/pipe_stage_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid_reg
// Description : Elastic pipeline-stage register with a 2-entry skid buffer,
//               a registered in_ready, flush, bubble gating and a stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid_reg #(
  parameter int DATA_W = 64,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  // State bits are {skid_valid, main_valid}.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  state_t              r_state;
  state_t              w_state_next;
  logic                w_accept;
  logic                w_drain;
  logic                w_load_main;
  logic                w_main_from_skid;
  logic                w_load_skid;
  logic                r_in_ready;
  logic [DATA_W-1:0]   r_main_data;
  logic [RD_W-1:0]     r_main_rd;
  logic [CTRL_W-1:0]   r_main_ctrl;
  logic [DATA_W-1:0]   r_skid_data;
  logic [RD_W-1:0]     r_skid_rd;
  logic [CTRL_W-1:0]   r_skid_ctrl;
  logic [CNT_W-1:0]    r_stall_cnt;

  assign w_accept = in_valid & r_in_ready;
  assign w_drain  = r_state[0] & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_state_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_load_main  = 1'b1;
            w_state_next = ST_FULL;
          end
        end
        ST_FULL: begin
          if (w_accept && w_drain) begin
            w_load_main = 1'b1;
          end else if (w_drain) begin
            w_state_next = ST_EMPTY;
          end else if (w_accept) begin
            w_load_skid  = 1'b1;
            w_state_next = ST_SKID;
          end
        end
        ST_SKID: begin
          if (w_drain) begin
            w_main_from_skid = 1'b1;
            w_state_next     = ST_FULL;
          end
        end
        default: w_state_next = ST_EMPTY;
      endcase
    end
  end

  // Ready is recomputed from the next state so it never depends on out_ready combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready <= 1'b0;
    end else begin
      r_in_ready <= (w_state_next != ST_SKID);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_data <= '0;
      r_main_rd   <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_rd   <= '0;
      r_skid_ctrl <= '0;
    end else begin
      if (w_load_main) begin
        r_main_data <= in_data;
        r_main_rd   <= in_rd;
        r_main_ctrl <= in_ctrl;
      end else if (w_main_from_skid) begin
        r_main_data <= r_skid_data;
        r_main_rd   <= r_skid_rd;
        r_main_ctrl <= r_skid_ctrl;
      end
      if (w_load_skid) begin
        r_skid_data <= in_data;
        r_skid_rd   <= in_rd;
        r_skid_ctrl <= in_ctrl;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (r_state[0] && !out_ready && (r_stall_cnt != c_cnt_max)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_state[0];
  assign out_data  = r_main_data;
  // Bubbles must never carry a register write.
  assign out_rd    = r_state[0] ? r_main_rd   : '0;
  assign out_ctrl  = r_state[0] ? r_main_ctrl : '0;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_skid_reg
// Description : Self-checking bench for pipe_stage_skid_reg against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid_reg;

  localparam int DATA_W = 64;
  localparam int RD_W   = 5;
  localparam int CTRL_W = 2;
  localparam int CNT_W  = 4;
  localparam int STALL_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [RD_W-1:0]   rd;
    logic [CTRL_W-1:0] ctrl;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [RD_W-1:0]   in_rd = '0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [RD_W-1:0]   out_rd;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  stall_cnt;

  beat_t m_q[$];
  bit    m_in_ready = 1'b0;
  int    m_stall = 0;
  int    n_checks = 0;
  int    n_pass = 0;

  pipe_stage_skid_reg #(
    .DATA_W(DATA_W), .RD_W(RD_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_rd(in_rd), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_model();
    beat_t h;
    bit    v;
    v = (m_q.size() > 0);
    h = v ? m_q[0] : '0;
    chk("in_ready", 64'(in_ready), 64'(m_in_ready));
    chk("out_valid", 64'(out_valid), 64'(v));
    chk("out_rd", 64'(out_rd), 64'(h.rd));
    chk("out_ctrl", 64'(out_ctrl), 64'(h.ctrl));
    if (v) chk("out_data", out_data, h.d);
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
  endtask

  task automatic drive(input bit v, input logic [DATA_W-1:0] d,
                       input logic [RD_W-1:0] rd, input logic [CTRL_W-1:0] c);
    in_valid = v;
    in_data  = d;
    in_rd    = rd;
    in_ctrl  = c;
  endtask

  // One clock: the model is a FIFO of at most two beats with a one-cycle-late ready.
  task automatic tick();
    bit    acc, drn, stl;
    beat_t b;
    acc = in_valid && m_in_ready;
    drn = (m_q.size() > 0) && out_ready;
    stl = (m_q.size() > 0) && !out_ready;
    b   = '{d: in_data, rd: in_rd, ctrl: in_ctrl};
    @(posedge clk);
    #1;
    if (stl && m_stall < STALL_MAX) m_stall++;
    if (flush) begin
      m_q.delete();
    end else begin
      if (drn) void'(m_q.pop_front());
      if (acc) m_q.push_back(b);
    end
    m_in_ready = (m_q.size() < 2);
    chk_model();
  endtask

  task automatic model_reset();
    m_q.delete();
    m_in_ready = 1'b0;
    m_stall    = 0;
  endtask

  initial begin
    // Reset state
    #3;
    model_reset();
    chk_model();
    chk("reset_out_data", out_data, 64'd0);
    #4 rst = 1'b0;
    tick();
    chk("ready_after_release", 64'(in_ready), 64'd1);

    // Streaming 1,2,3,4
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, DATA_W'(i), RD_W'(i), CTRL_W'(i));
      tick();
      chk("stream_data", out_data, 64'(i));
    end
    drive(1'b0, '0, '0, '0);
    tick();
    chk("stream_stall", 64'(stall_cnt), 64'd0);

    // Backpressure into the skid entry
    out_ready = 1'b0;
    drive(1'b1, 64'h11, 5'd1, 2'b01);
    tick();
    drive(1'b1, 64'h22, 5'd2, 2'b10);
    tick();
    drive(1'b0, '0, '0, '0);
    chk("skid_ready_low", 64'(in_ready), 64'd0);
    tick();
    tick();
    chk("stall_three", 64'(stall_cnt), 64'd3);
    chk("hold_A", out_data, 64'h11);
    out_ready = 1'b1;
    tick();
    chk("then_B", out_data, 64'h22);
    chk("ready_back", 64'(in_ready), 64'd1);
    tick();

    // Bubble gating
    drive(1'b1, 64'hABCD, 5'd31, 2'b11);
    tick();
    chk("bubble_ctrl_live", 64'(out_ctrl), 64'd3);
    drive(1'b0, '0, '0, '0);
    tick();
    chk("bubble_ctrl", 64'(out_ctrl), 64'd0);
    chk("bubble_rd", 64'(out_rd), 64'd0);

    // Flush colliding with accept and drain in SKID
    out_ready = 1'b0;
    drive(1'b1, 64'h33, 5'd3, 2'b11);
    tick();
    drive(1'b1, 64'h44, 5'd4, 2'b11);
    tick();
    drive(1'b1, 64'h55, 5'd5, 2'b11);
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) tick();

    // Async reset while in SKID with stall_cnt=5
    out_ready = 1'b0;
    drive(1'b1, 64'h66, 5'd6, 2'b01);
    for (int i = 0; i < 20 && m_stall < 5; i++) tick();
    drive(1'b0, '0, '0, '0);
    chk("pre_reset_stall", 64'(stall_cnt), 64'd5);
    chk("pre_reset_skid", 64'(in_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk_model();
    chk("async_out_data", out_data, 64'd0);
    #3 rst = 1'b0;
    tick();
    drive(1'b1, 64'h77, 5'd7, 2'b10);
    tick();
    chk("post_reset_latency", out_data, 64'h77);
    drive(1'b0, '0, '0, '0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), {$urandom, $urandom}, RD_W'($urandom), CTRL_W'($urandom));
      out_ready = 1'($urandom);
      flush     = ($urandom_range(0, 15) == 0);
      tick();
    end
    flush = 1'b0;

    // Saturation
    rst = 1'b1;
    #1;
    model_reset();
    #1 rst = 1'b0;
    tick();
    out_ready = 1'b0;
    drive(1'b1, 64'h88, 5'd8, 2'b01);
    tick();
    drive(1'b0, '0, '0, '0);
    for (int i = 0; i < 20; i++) tick();
    chk("stall_saturated", 64'(stall_cnt), 64'd15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Parametrised, elastic pipeline-stage register for the MIPS pipeline.
- Generalises the fixed ME/WB latch into a reusable stage that can be placed between any two pipeline stages.
- Carries a payload, a destination register index and a control bundle under a valid/ready handshake, with a 2-entry skid buffer so upstream ready is registered.
- Adds synchronous flush (bubble insertion), control gating on bubbles and a saturating stall counter for performance debug.

Parameters:
- DATA_W, 64, payload width (e.g. ALU result plus memory read data).
- RD_W, 5, destination register index width.
- CTRL_W, 2, control bundle width (e.g. {Mem2Reg, regWr}).
- CNT_W, 16, stall counter width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous flush; empties the stage.
- in_valid  input  1  upstream has a beat.
- in_ready  output  1  stage can accept a beat; registered.
- in_data  input  DATA_W  upstream payload.
- in_rd  input  RD_W  upstream destination register.
- in_ctrl  input  CTRL_W  upstream control bundle.
- out_valid  output  1  stage presents a beat.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  DATA_W  payload of the main entry.
- out_rd  output  RD_W  destination register; 0 when out_valid=0.
- out_ctrl  output  CTRL_W  control bundle; 0 when out_valid=0.
- stall_cnt  output  CNT_W  count of cycles with out_valid=1 and out_ready=0; saturating.

Behaviour:
- Storage: a main entry (drives the outputs) and a skid entry. Each entry holds data, rd, ctrl and a valid bit.
- Transfers:
  - Accept occurs when in_valid and in_ready are both 1 at a rising edge.
  - Drain occurs when out_valid and out_ready are both 1 at a rising edge.
- States: EMPTY (main invalid), FULL (main valid, skid invalid), SKID (both valid). The state encodes the valid bits.
- in_ready = 1 in EMPTY and FULL, 0 in SKID. It is a flop output and has no combinational path from out_ready.
- EMPTY: accept loads main -> FULL. Otherwise stay in EMPTY.
- FULL:
  - accept and drain: main <= input, stay FULL.
  - drain only: -> EMPTY.
  - accept only: skid <= input -> SKID.
  - neither: hold.
- SKID:
  - drain: main <= skid, skid invalid -> FULL.
  - otherwise hold; no accept is possible.
- Timing:
  - Latency is 1 cycle from accept to out_valid when the stage was empty.
  - Sustained throughput is 1 beat/cycle while out_ready=1.
  - Beat order is strictly preserved. No beat is ever duplicated or lost, except by flush.
- Flush (synchronous):
  - The next state is EMPTY, with both valid bits cleared.
  - Flush has priority over accept and drain in the same cycle. A beat handshaken in that cycle is discarded; upstream treats it as taken.
  - The data/rd/ctrl payload registers are not cleared.
  - Because out_rd and out_ctrl are gated, they read 0 the cycle after a flush.
- Bubble gating: out_ctrl and out_rd are forced to 0 whenever out_valid=0, so regWr never fires on a bubble. out_data holds its last value and is don't-care when out_valid=0.
- stall_cnt:
  - Increments by 1 each cycle with out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1.
  - Unaffected by flush; cleared only by rst.
- Reset (asynchronous, any time including mid-transfer): state EMPTY, in_ready=0 while rst is asserted and 1 from the first edge after release, out_valid=0, out_data=0, out_rd=0, out_ctrl=0, stall_cnt=0, skid cleared.
- Payload widths are carried unmodified; there is no arithmetic on the payload.

Test Plan:
- Streaming: out_ready=1, in_valid=1 for 4 cycles with data 1,2,3,4 -> out_valid rises 1 cycle after the first accept; outputs 1,2,3,4 on consecutive cycles; in_ready stays 1; stall_cnt=0.
- Backpressure/skid:
  - Send A=0x11 then hold out_ready=0 and present B=0x22 -> B goes to skid and in_ready drops to 0 the next cycle; stall_cnt increments each held cycle (3 after 3 cycles).
  - Raise out_ready -> A then B appear in order; in_ready returns to 1 after A drains.
- Flush collision: in SKID state, assert flush with in_valid=1 and out_ready=1 -> next cycle out_valid=0, out_ctrl=0, out_rd=0, in_ready=1; neither the held beats nor the new beat is ever output.
- Bubble gating: in_ctrl=2'b11, in_rd=5'd31, then in_valid=0 -> after the beat drains, out_ctrl=0 and out_rd=0 while out_valid=0.
- Async reset mid-operation: assert rst between edges while in SKID with stall_cnt=5 -> all outputs 0 and stall_cnt=0 immediately, without waiting for clk; after release the stage behaves as EMPTY.
- Saturation: with CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays at 15.
